// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity
// helper. Intended to be reused unchanged by the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity over a zero-extended payload; the padding zeros do not change the XOR.
    function automatic logic parity_bit(input int mode, input logic [8:0] data);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT cycles.
// Restart holds the count at zero so the next bit starts a full period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick = (cnt_q == LAST) && !i_restart;

    // Count up, wrapping at the end of each bit period or on restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (i_restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register, so the
// next byte can wait while the current frame is on the line.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 load_frame;
    logic                 frame_par;
    logic [8:0]           par_src;
    logic                 baud_tick;

    // The bit timer sits at zero while idle so a new frame gets a full start bit.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(state_q == IDLE),
        .o_tick   (baud_tick)
    );

    assign o_ready = !hold_full_q;
    assign o_busy  = (state_q != IDLE) || hold_full_q;
    assign o_tx    = tx_q;

    // Parity of the held byte, latched when that byte becomes the live frame.
    always_comb begin
        par_src                  = '0;
        par_src[DATA_BITS-1:0]   = hold_data_q;
        frame_par                = parity_bit(PARITY, par_src);
    end

    // Frame sequencing, holding-register accept/release and next line bit.
    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        load_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    load_frame = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (hold_full_q) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Move the held byte onto the line; start bit goes out on this edge.
        if (load_frame) begin
            state_d     = START;
            tx_d        = 1'b0;
            shift_d     = hold_data_q;
            par_d       = frame_par;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
        end

        // Accept only into an empty holding register (never collides with a load).
        if (i_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = i_data;
        end
    end

    // State registers; reset idles the line and drops any held byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7N2), all at
// 4 clocks per bit, checked cycle by cycle against an expected-line queue.
module tb_uart_tx_cfg;
    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] valid_r;
    logic [8:0] data_r [4];
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] ready_w;

    int nbits [4] = '{8, 8, 8, 7};
    int pmode [4] = '{0, 2, 1, 0};
    int nstop [4] = '{1, 1, 1, 2};

    int   checks = 0;
    int   errors = 0;
    logic exp_q [$];

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_r[0]), .i_data(data_r[0][7:0]),
        .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_r[1]), .i_data(data_r[1][7:0]),
        .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_r[2]), .i_data(data_r[2][7:0]),
        .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]));
    uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_r[3]), .i_data(data_r[3][6:0]),
        .o_ready(ready_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_bit(input logic b);
        for (int c = 0; c < CPB; c++) exp_q.push_back(b);
    endfunction

    // Expected line, one entry per clock, for a frame on instance inst.
    function automatic void push_frame(input int inst, input logic [8:0] d);
        logic [8:0] m;
        m = d & ((9'h1 << nbits[inst]) - 9'h1);
        push_bit(1'b0);
        for (int i = 0; i < nbits[inst]; i++) push_bit(m[i]);
        if (pmode[inst] == 2) push_bit(^m);
        if (pmode[inst] == 1) push_bit(~(^m));
        for (int i = 0; i < nstop[inst]; i++) push_bit(1'b1);
    endfunction

    task automatic test_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_w[i] !== 1'b1) begin errors++; $display("FAIL reset_tx_async inst %0d tx=%b expected 1", i, tx_w[i]); end
            checks++;
            if (busy_w[i] !== 1'b0) begin errors++; $display("FAIL reset_busy_async inst %0d busy=%b expected 0", i, busy_w[i]); end
            checks++;
            if (ready_w[i] !== 1'b1) begin errors++; $display("FAIL reset_ready_async inst %0d ready=%b expected 1", i, ready_w[i]); end
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release inst %0d tx/busy/ready=%b%b%b expected 101", i, tx_w[i], busy_w[i], ready_w[i]);
            end
        end
        $display("reset: outputs checked on all instances");
    endtask

    // One isolated frame: accept, exact per-cycle line, then idle.
    task automatic test_frame(input int inst, input logic [8:0] d, input string name);
        logic e;
        int   k;
        exp_q.delete();
        push_frame(inst, d);
        @(posedge clk); #1;
        valid_r[inst] = 1'b1;
        data_r[inst]  = d;
        @(posedge clk); #1;
        valid_r[inst] = 1'b0;
        checks++;
        if (ready_w[inst] !== 1'b0 || busy_w[inst] !== 1'b1 || tx_w[inst] !== 1'b1) begin
            errors++;
            $display("FAIL %s_held ready/busy/tx=%b%b%b expected 011", name, ready_w[inst], busy_w[inst], tx_w[inst]);
        end
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (tx_w[inst] !== e) begin
                errors++;
                $display("FAIL %s_line cycle %0d tx=%b expected %b", name, k, tx_w[inst], e);
            end
            k++;
        end
        @(posedge clk); #1;
        checks++;
        if (busy_w[inst] !== 1'b0 || tx_w[inst] !== 1'b1 || ready_w[inst] !== 1'b1) begin
            errors++;
            $display("FAIL %s_end busy/tx/ready=%b%b%b expected 011", name, busy_w[inst], tx_w[inst], ready_w[inst]);
        end
        $display("frame %s: inst %0d data 0x%h, %0d cycles", name, inst, d, k);
    endtask

    // 0x00 then 0xFF with valid held: frames must abut with no idle cycle.
    task automatic test_back_to_back();
        logic e;
        int   k;
        exp_q.delete();
        push_frame(0, 9'h000);
        push_frame(0, 9'h0FF);
        @(posedge clk); #1;
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h000;
        @(posedge clk); #1;
        checks++;
        if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_first_held ready=%b expected 0", ready_w[0]); end
        data_r[0] = 9'h0FF;
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (k == 1) begin
                valid_r[0] = 1'b0;
                checks++;
                if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_held ready=%b expected 0", ready_w[0]); end
            end
            if (k == CPB * 10 - 1) begin
                checks++;
                if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_last_stop ready=%b expected 0", ready_w[0]); end
            end
            if (k == CPB * 10) begin
                checks++;
                if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_released ready=%b expected 1", ready_w[0]); end
            end
            e = exp_q.pop_front();
            checks++;
            if (tx_w[0] !== e) begin
                errors++;
                $display("FAIL b2b_line cycle %0d tx=%b expected %b", k, tx_w[0], e);
            end
            k++;
        end
        @(posedge clk); #1;
        checks++;
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_end busy=%b expected 0", busy_w[0]); end
        $display("frame b2b: 0x00 then 0xFF, %0d cycles", k);
    endtask

    // Reset mid-DATA with a byte held: line rises at once, nothing follows.
    task automatic test_reset_midframe();
        logic seen_bad;
        @(posedge clk); #1;
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h0C3;
        @(posedge clk); #1;
        valid_r[0] = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                valid_r[0] = 1'b1;
                data_r[0]  = 9'h03C;
            end
            if (k == 6) begin
                valid_r[0] = 1'b0;
                checks++;
                if (ready_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_held ready/busy=%b%b expected 01", ready_w[0], busy_w[0]);
                end
            end
        end
        checks++;
        if (tx_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_data_bit tx=%b expected 0", tx_w[0]); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_tx_async tx=%b expected 1", tx_w[0]); end
        checks++;
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async busy=%b expected 0", busy_w[0]); end
        checks++;
        if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready_async ready=%b expected 1", ready_w[0]); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) seen_bad = 1'b1;
        end
        checks++;
        if (seen_bad !== 1'b0) begin errors++; $display("FAIL rstmid_residual activity seen=%b expected 0", seen_bad); end
        $display("reset mid-frame: inst 0 checked");
    endtask

    initial begin
        rst     = 1'b1;
        valid_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = '0;
        test_reset();
        test_frame(0, 9'h0A5, "8n1_a5");
        test_frame(1, 9'h0A5, "8e1_a5");
        test_frame(2, 9'h0A5, "8o1_a5");
        test_frame(3, 9'h055, "7n2_55");
        test_frame(1, 9'h013, "8e1_13");
        test_back_to_back();
        test_reset_midframe();
        test_frame(0, 9'h03C, "8n1_after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
